k16_mem_arbiter: RTL and testbench
==================================

// Module: k16_mem_arbiter
// PURPOSE
//  Single-port RAM arbiter between the K16 CPU bus and the VGA pixel fetcher.
//  Sits directly downstream of the CPU address/data/write bus.
//  Drives the CPU hold input whenever the CPU loses arbitration.
//  Video has priority; a run-length guard bounds CPU starvation.
// PARAMETERS
//  AW           16  address width (word address)
//  DW           16  data width
//  MAX_VID_RUN  8   max consecutive video grants while CPU pending (1..255)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  cpu_req    in   1   CPU requests a RAM cycle this clock
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_we     in   1   1=write, 0=read (qualified by cpu_req)
//  cpu_hold   out  1   CPU must stall and hold request stable
//  cpu_ack    out  1   pulse: CPU cycle granted last clock completed
//  cpu_rdata  out  DW  read data, valid when cpu_ack
//  vid_req    in   1   video read request
//  vid_addr   in   AW  video read address
//  vid_valid  out  1   pulse: vid_rdata valid (for grant of previous clock)
//  vid_rdata  out  DW  video read data
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  DW  RAM write data
//  mem_we     out  1   RAM write enable
//  mem_rdata  in   DW  RAM read data, 1-clock synchronous latency
// BEHAVIOUR
//  - Grant is combinational, once per clock:
//    gnt_vid = vid_req & ~(cpu_req & run_cnt == MAX_VID_RUN);
//    gnt_cpu = cpu_req & ~gnt_vid.
//  - mem_addr/mem_wdata/mem_we: muxed from the granted source.
//    mem_we = gnt_cpu & cpu_we. With no grant: mem_addr = cpu_addr, mem_we = 0.
//  - cpu_hold = cpu_req & ~gnt_cpu (combinational, same clock).
//  - Tag register: pend_vid <= gnt_vid; pend_cpu <= gnt_cpu.
//  - Next clock:
//    vid_valid = pend_vid, vid_rdata = mem_rdata;
//    cpu_ack = pend_cpu, cpu_rdata = mem_rdata.
//    Both are pass-through of mem_rdata; a write also gets cpu_ack.
//  - Latency: read data one clock after grant; zero-wait when uncontended.
//  - run_cnt (8 bit):
//    increments when gnt_vid & cpu_req;
//    clears on gnt_cpu or when ~cpu_req;
//    saturates at MAX_VID_RUN.
//  - At MAX_VID_RUN the CPU wins exactly one clock. The video request is
//    dropped that clock; the requester must keep vid_req asserted and retry.
//  - Simultaneous vid_req & cpu_req below the limit: video wins, cpu_hold=1.
//  - Back-to-back CPU grants allowed every clock.
//  - Reset:
//    pend_vid = pend_cpu = 0, run_cnt = 0;
//    vid_valid = cpu_ack = 0; mem_we forced 0.
//    cpu_hold = cpu_req, so the CPU is stalled during reset.
//    A cycle in flight at reset is discarded (no ack/valid after release).
//  - Address wrap: none; addresses pass through unmodified.
// CONFIGURATION
//  K16_ARB_STATS_EN defined:
//    adds output stall_cnt [31:0], counting clocks with cpu_hold=1.
//    Cleared by reset; wraps at 2^32.
//  Not defined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package/header k16_bus_defs:
//    K16_AW/K16_DW constants, grant encoding localparams (GNT_NONE/VID/CPU).
//  No sub-module; the arbiter is flat. Grant logic may be a function.
// TESTING
//  1. CPU-only read at 0x0010 (RAM=0xBEEF): hold=0; next clk cpu_ack=1,
//     cpu_rdata=0xBEEF.
//  2. CPU write 0x1234 to 0x0020: mem_we=1 same clk; readback -> 0x1234.
//  3. vid_req and cpu_req together: vid granted, cpu_hold=1;
//     vid_valid next clk; CPU granted when vid_req drops.
//  4. vid_req held high, cpu_req high, MAX_VID_RUN=8: 8 vid grants,
//     then 1 CPU grant (cpu_ack), run_cnt back to 0.
//  5. Reset asserted one clk after a CPU grant: no cpu_ack after release;
//     mem_we=0 during reset.
//  6. K16_ARB_STATS_EN: 5 held clocks -> stall_cnt=5; reset -> 0.

Source files
------------

// File: rtl/k16_bus_defs.sv
// rtl/k16_bus_defs.sv - K16 bus widths, grant encoding and the arbiter grant function.
package k16_bus_defs;

    localparam int K16_AW = 16;
    localparam int K16_DW = 16;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_VID  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;

    // Video wins unless the CPU has waited out a full video run; nothing is granted in reset.
    function automatic logic [1:0] arb_grant(
        input logic reset,
        input logic vid_req,
        input logic cpu_req,
        input logic run_at_limit
    );
        logic [1:0] g;
        g = GNT_NONE;
        if (!reset) begin
            if (vid_req && !run_at_limit)
                g = GNT_VID;
            else if (cpu_req)
                g = GNT_CPU;
        end
        return g;
    endfunction

endpackage

// File: rtl/k16_mem_arbiter.sv
// rtl/k16_mem_arbiter.sv - single-port RAM arbiter, VGA fetch over K16 CPU with bounded starvation.
// Optional stall counter output stall_cnt when K16_ARB_STATS_EN is defined.
module k16_mem_arbiter
    import k16_bus_defs::*;
#(
    parameter int AW          = K16_AW,
    parameter int DW          = K16_DW,
    parameter int MAX_VID_RUN = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic          cpu_hold,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef K16_ARB_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam logic [7:0] RUN_LIMIT = 8'(MAX_VID_RUN);

    logic [7:0] run_cnt;
    logic       run_at_limit;
    logic [1:0] gnt;
    logic       gnt_vid;
    logic       gnt_cpu;
    logic       pend_vid;
    logic       pend_cpu;

    assign run_at_limit = cpu_req && (run_cnt == RUN_LIMIT);
    assign gnt          = arb_grant(reset, vid_req, cpu_req, run_at_limit);
    assign gnt_vid      = (gnt == GNT_VID);
    assign gnt_cpu      = (gnt == GNT_CPU);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (gnt_vid) begin
            mem_addr = vid_addr;
        end else if (gnt_cpu) begin
            mem_we = cpu_we;
        end
    end

    assign cpu_hold = cpu_req && !gnt_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vid <= 1'b0;
            pend_cpu <= 1'b0;
            run_cnt  <= 8'd0;
        end else begin
            pend_vid <= gnt_vid;
            pend_cpu <= gnt_cpu;
            if (gnt_cpu || !cpu_req)
                run_cnt <= 8'd0;
            else if (gnt_vid && run_cnt != RUN_LIMIT)
                run_cnt <= run_cnt + 8'd1;
        end
    end

    // Tags are masked during reset so a cycle in flight never reports completion.
    assign cpu_ack   = pend_cpu && !reset;
    assign vid_valid = pend_vid && !reset;
    assign cpu_rdata = mem_rdata;
    assign vid_rdata = mem_rdata;

`ifdef K16_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 32'd0;
        else if (cpu_hold)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// tb/tb_k16_mem_arbiter.sv - directed and randomized bench for k16_mem_arbiter against a transaction model.
module tb_k16_mem_arbiter;

    localparam int MAX_RUN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_hold;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_valid;
    logic [15:0] vid_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
`ifdef K16_ARB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    k16_mem_arbiter #(.AW(16), .DW(16), .MAX_VID_RUN(MAX_RUN)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_hold  (cpu_hold),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef K16_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM with one-clock read latency, read-before-write; preload port used while the DUT is idle.
    logic [15:0] ram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [15:0] pre_data = 16'd0;

    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
    end

    // Reference model: expected memory contents and transaction bookkeeping.
    logic [15:0] shadow [0:255];
    int          m_wait_run;
    bit          m_ack_due, m_valid_due, m_ack_is_read;
    logic [15:0] m_ack_data, m_valid_data;
    bit          m_last_cpu_won, m_last_hold;
    int unsigned m_stall;
    bit          m_stall_known;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step(input bit rst, input bit cr, input bit cwe, input logic [15:0] ca,
                        input logic [15:0] cd, input bit vr, input logic [15:0] va);
        bit vid_wins, cpu_wins;
        reset = rst; cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        vid_req = vr; vid_addr = va;
        #3;
        vid_wins = !rst && vr && !(cr && m_wait_run >= MAX_RUN);
        cpu_wins = !rst && cr && !vid_wins;
        check("cpu_hold", cpu_hold, cr && !cpu_wins);
        check("mem_we", mem_we, cpu_wins && cwe);
        check("mem_addr", mem_addr, vid_wins ? va : ca);
        if (cpu_wins && cwe) check("mem_wdata", mem_wdata, cd);
        check("cpu_ack", cpu_ack, !rst && m_ack_due);
        check("vid_valid", vid_valid, !rst && m_valid_due);
        if (!rst && m_ack_due && m_ack_is_read) check("cpu_rdata", cpu_rdata, m_ack_data);
        if (!rst && m_valid_due) check("vid_rdata", vid_rdata, m_valid_data);
`ifdef K16_ARB_STATS_EN
        if (m_stall_known) check("stall_cnt", stall_cnt, m_stall);
`endif
        m_ack_due     = cpu_wins;
        m_ack_is_read = cpu_wins && !cwe;
        m_ack_data    = shadow[ca[7:0]];
        m_valid_due   = vid_wins;
        m_valid_data  = shadow[va[7:0]];
        if (cpu_wins && cwe) shadow[ca[7:0]] = cd;
        m_wait_run     = (cr && vid_wins) ? m_wait_run + 1 : 0;
        m_last_cpu_won = cpu_wins;
        m_last_hold    = cr && !cpu_wins;
        if (rst) begin
            m_stall = 0;
            m_stall_known = 1'b1;
        end else if (m_last_hold) begin
            m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          r_cr, r_cwe, r_vr, r_rst, found;
        logic [15:0] r_ca, r_cd, r_va;
        int          n;

        m_wait_run = 0; m_ack_due = 0; m_valid_due = 0; m_ack_is_read = 0;
        m_ack_data = '0; m_valid_data = '0; m_last_cpu_won = 0; m_last_hold = 0;
        m_stall = 0; m_stall_known = 0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            pre_we = 1'b1;
            pre_addr = 16'(i);
            pre_data = (i == 16) ? 16'hBEEF : 16'(i * 40503) ^ 16'h5A5A;
            shadow[i] = pre_data;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        step(1, 1, 1, 16'h0005, 16'h1111, 1, 16'h0080);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        // CPU-only read
        step(0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
        check("t1_ack", cpu_ack, 1);
        check("t1_rdata", cpu_rdata, 16'hBEEF);

        // CPU write then readback
        step(0, 1, 1, 16'h0020, 16'h1234, 0, 16'h0000);
        step(0, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000);
        check("t2_readback", cpu_rdata, 16'h1234);

        // Contention, then CPU when video drops
        step(0, 1, 0, 16'h0030, 16'h0000, 1, 16'h0090);
        step(0, 1, 0, 16'h0030, 16'h0000, 0, 16'h0000);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        // Starvation guard: exactly MAX_RUN video grants then one CPU grant
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 1, 0, 16'h0031, 16'h0000, 1, 16'(16'h00A0 + i));
            if (m_last_cpu_won) found = 1; else n++;
        end
        check("t4_vid_run", 32'(n), 32'(MAX_RUN));
        step(0, 1, 0, 16'h0032, 16'h0000, 1, 16'h00B0);
        check("t4_restart_hold", cpu_hold, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        // Reset one clock after a CPU grant discards it
        step(0, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000);
        step(1, 1, 1, 16'h0041, 16'h7777, 1, 16'h0090);
        step(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        check("t5_no_ack", cpu_ack, 0);

`ifdef K16_ARB_STATS_EN
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 16'h0050, 16'h0000, 1, 16'h0080);
        check("t6_stall5", stall_cnt, 32'd5);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        check("t6_clear", stall_cnt, 32'd0);
`endif

        // Randomized traffic; a held CPU keeps its request stable
        r_cr = 0; r_cwe = 0; r_ca = '0; r_cd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!m_last_hold) begin
                r_cr  = ($urandom % 4) != 0;
                r_cwe = ($urandom % 3) == 0;
                r_ca  = 16'($urandom % 256);
                r_cd  = 16'($urandom);
            end
            r_vr  = ($urandom % 10) < 7;
            r_va  = 16'($urandom % 256);
            r_rst = ($urandom % 64) == 0;
            step(r_rst, r_cr, r_cwe, r_ca, r_cd, r_vr, r_va);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
